cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache controller between the MEM stage and the SRAM controller. It serves read hits in zero extra cycles and turns read misses and all writes into SRAM-controller transactions. It holds `mem_ready` low (pipeline freeze) until each transaction completes. One word per line; byte addresses from 1024 upward pass through to the SRAM controller unchanged.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_array.sv | 75 +++++++
 rtl/cache_controller.sv | 112 +++++++++++
 tb/tb_cache_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the two-way write-through data cache.
package cache_pkg;

  localparam int SETS    = 64;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 30 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE_THROUGH
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[INDEX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:INDEX_W+2];
  endfunction

endpackage

// File: rtl/cache_array.sv
// Two-way tag/valid/data storage with per-set LRU bit, combinational lookup,
// miss-fill and write-hit update ports.
module cache_array
  import cache_pkg::*;
#(
  parameter int SETS    = cache_pkg::SETS,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W   = cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic [31:0]        hit_data,
  input  logic               fill_en,
  input  logic [31:0]        fill_data,
  input  logic               write_en,
  input  logic [31:0]        write_data,
  input  logic               touch_en
);

  logic [1:0]       valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [31:0]      data_q  [SETS][2];
  logic [SETS-1:0]  lru_q;

  logic [1:0] way_hit;
  logic       hit_way;
  logic       victim;

  // A tag can live in at most one way, so way1 is the hit way whenever way0 misses.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[index][w] && (tag_q[index][w] == tag);
    end
    hit      = |way_hit;
    hit_way  = ~way_hit[0];
    hit_data = data_q[index][hit_way];
    if (!valid_q[index][0]) begin
      victim = 1'b0;
    end else if (!valid_q[index][1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[index];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
      lru_q <= '0;
    end else if (fill_en) begin
      valid_q[index][victim] <= 1'b1;
      lru_q[index]           <= ~victim;
    end else if ((write_en || touch_en) && hit) begin
      lru_q[index] <= ~hit_way;
    end
  end

  // Tag and data need no clear; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        tag_q[index][victim]  <= tag;
        data_q[index][victim] <= fill_data;
      end else if (write_en && hit) begin
        data_q[index][hit_way] <= write_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative write-through, no-write-allocate cache controller
// sitting between the MEM stage and the SRAM controller.
module cache_controller
  import cache_pkg::*;
#(
  parameter int SETS    = cache_pkg::SETS,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W   = cache_pkg::TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);

  state_t state_q, state_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill_en;
  logic        wt_done;
  logic        touch_en;

  assign sram_address    = mem_address;
  assign sram_write_data = mem_write_data;

  cache_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (mem_address[INDEX_W+1:2]),
    .tag        (mem_address[31:INDEX_W+2]),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_data  (sram_read_data),
    .write_en   (wt_done),
    .write_data (mem_write_data),
    .touch_en   (touch_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces every output quiet so an abandoned miss never fills the array.
  always_comb begin
    state_d       = state_q;
    mem_ready     = 1'b0;
    mem_read_data = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    fill_en       = 1'b0;
    wt_done       = 1'b0;
    touch_en      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_write_en) begin
            state_d = WRITE_THROUGH;
          end else if (mem_read_en) begin
            if (hit) begin
              mem_ready     = 1'b1;
              mem_read_data = hit_data;
              touch_en      = 1'b1;
            end else begin
              state_d = READ_MISS;
            end
          end else begin
            mem_ready = 1'b1;
          end
        end
        READ_MISS: begin
          sram_read_en = 1'b1;
          mem_ready    = sram_ready;
          if (sram_ready) begin
            mem_read_data = sram_read_data;
            fill_en       = 1'b1;
            state_d       = IDLE;
          end
        end
        WRITE_THROUGH: begin
          sram_write_en = 1'b1;
          mem_ready     = sram_ready;
          if (sram_ready) begin
            wt_done = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: SRAM stub ready on the 4th request cycle, reference
// model keeps each set as a recency-ordered list of at most two lines.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data = '0;
  logic        sram_ready;

  int total = 0;
  int bad   = 0;
  int stub_cnt = 0;

  logic [31:0] backing [int unsigned];

  logic [31:0] m_addr [64][2];
  logic [31:0] m_data [64][2];
  int          m_cnt  [64];

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .mem_ready       (mem_ready),
    .sram_read_en    (sram_read_en),
    .sram_write_en   (sram_write_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bk(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // SRAM stub: ready drops as soon as a request appears and returns on its 4th cycle.
  assign sram_ready = !(sram_read_en || sram_write_en) || (stub_cnt == 3);

  always @(posedge clk) begin
    if ((sram_read_en || sram_write_en) && !sram_ready) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
    sram_read_data <= bk(sram_address);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  task automatic m_promote(input int s, input int pos);
    logic [31:0] ta, td;
    if (pos == 1) begin
      ta = m_addr[s][0]; td = m_data[s][0];
      m_addr[s][0] = m_addr[s][1]; m_data[s][0] = m_data[s][1];
      m_addr[s][1] = ta; m_data[s][1] = td;
    end
  endtask

  // Drive one request from just after a rising edge until its completion edge has passed.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                               output int lat, output logic [31:0] rdata, output int rdc, output int wrc);
    bit done = 0;
    bit pass_ok = 1;
    lat = 0; rdc = 0; wrc = 0; rdata = '0;
    mem_read_en = rd; mem_write_en = wr; mem_address = a; mem_write_data = wd;
    while (!done) begin
      @(negedge clk);
      if (sram_read_en) rdc++;
      if (sram_write_en) wrc++;
      if ((sram_read_en || sram_write_en) && (sram_address !== a || sram_write_data !== wd)) pass_ok = 0;
      if (mem_ready) begin
        done = 1;
        rdata = mem_read_data;
      end else begin
        lat++;
        if (lat > 20) begin
          checkOutput("timeout", 32'(mem_ready), 32'd1);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("sram_passthru", 32'(pass_ok), 32'd1);
    mem_read_en = 1'b0; mem_write_en = 1'b0;
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input string name);
    int s, pos, lat, rdc, wrc, exp_lat, exp_rd, exp_wr;
    logic [31:0] rdata, exp_data;
    s = int'((a / 4) % 64);
    pos = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_addr[s][i] == a) pos = i;
    exp_data = '0;
    if (wr) begin
      exp_lat = 4; exp_rd = 0; exp_wr = 4;
    end else if (pos >= 0) begin
      exp_lat = 0; exp_rd = 0; exp_wr = 0; exp_data = m_data[s][pos];
    end else begin
      exp_lat = 4; exp_rd = 4; exp_wr = 0; exp_data = bk(a);
    end
    applyStimulus(rd, wr, a, wd, lat, rdata, rdc, wrc);
    checkOutput({name, ".lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, ".rd_cycles"}, 32'(rdc), 32'(exp_rd));
    checkOutput({name, ".wr_cycles"}, 32'(wrc), 32'(exp_wr));
    if (rd && !wr) checkOutput({name, ".data"}, rdata, exp_data);
    if (wr) begin
      backing[a] = wd;
      if (pos >= 0) begin
        m_data[s][pos] = wd;
        m_promote(s, pos);
      end
    end else if (pos >= 0) begin
      m_promote(s, pos);
    end else begin
      m_addr[s][1] = m_addr[s][0]; m_data[s][1] = m_data[s][0];
      m_addr[s][0] = a;            m_data[s][0] = exp_data;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int op;
    rst = 1'b1; mem_read_en = 1'b1; mem_write_en = 1'b0;
    mem_address = 32'h400; mem_write_data = '0;
    m_reset();
    backing[32'h400] = 32'hDEADBEEF;

    @(negedge clk);
    checkOutput("rst.mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst.sram_rd", 32'(sram_read_en), 32'd0);
    checkOutput("rst.sram_wr", 32'(sram_write_en), 32'd0);
    checkOutput("rst.rdata", mem_read_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; mem_read_en = 1'b0;
    @(negedge clk);
    checkOutput("idle.mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("idle.sram_rd", 32'(sram_read_en), 32'd0);
    @(posedge clk); #1;

    $display("[TB] cold miss then hit");
    run_op(1, 0, 32'h400, '0, "t1.cold");
    run_op(1, 0, 32'h400, '0, "t1.hit");

    $display("[TB] eviction");
    run_op(1, 0, 32'h500, '0, "t2.fill500");
    run_op(1, 0, 32'h600, '0, "t2.fill600");
    run_op(1, 0, 32'h500, '0, "t2.hit500");
    run_op(1, 0, 32'h400, '0, "t2.miss400");

    $display("[TB] write hit");
    run_op(1, 0, 32'h404, '0, "t3.fill");
    run_op(0, 1, 32'h404, 32'h12345678, "t3.write");
    run_op(1, 0, 32'h404, '0, "t3.readback");

    $display("[TB] write miss");
    run_op(0, 1, 32'h808, 32'hCAFEF00D, "t4.write");
    run_op(1, 0, 32'h808, '0, "t4.read");

    $display("[TB] reset mid-miss");
    mem_read_en = 1'b1; mem_address = 32'h40C;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5.miss_rd", 32'(sram_read_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5.rst_ready", 32'(mem_ready), 32'd0);
    checkOutput("t5.rst_rd", 32'(sram_read_en), 32'd0);
    checkOutput("t5.rst_rdata", mem_read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_read_en = 1'b0;
    @(negedge clk);
    checkOutput("t5.after_rd", 32'(sram_read_en), 32'd0);
    checkOutput("t5.after_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    m_reset();
    run_op(1, 0, 32'h400, '0, "t5.miss400");
    run_op(1, 0, 32'h40C, '0, "t5.miss40C");

    $display("[TB] simultaneous enables");
    run_op(1, 1, 32'h410, 32'h0BADF00D, "t6.both");

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      a  = 32'h400 + 32'($urandom_range(0, 3)) * 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
      op = int'($urandom_range(0, 9));
      if (op <= 5)      run_op(1, 0, a, $urandom, "rnd.read");
      else if (op <= 8) run_op(0, 1, a, $urandom, "rnd.write");
      else              run_op(1, 1, a, $urandom, "rnd.both");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
